// File: rtl/psram_pwr_seq.sv
// Power-up sequencer for a PSRAM controller: filters PLL lock, holds the controller
// in reset, waits out the power-up time, then handshakes the init sequence.
module psram_pwr_seq #(
  parameter int LOCK_FILTER  = 64,
  parameter int RST_HOLD     = 16,
  parameter int PWRUP_CYCLES = 8100,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       init_ack,
  output logic       ctrl_rst,
  output logic       init_req,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt,
  output logic [2:0] state
);

  localparam int MAX_AB = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int MAX_CD = (PWRUP_CYCLES > INIT_TIMEOUT) ? PWRUP_CYCLES : INIT_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] LD_FILTER = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_INIT   = CNT_W'(INIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILTER = 3'd1,
    S_HOLD   = 3'd2,
    S_PWRUP  = 3'd3,
    S_INIT   = 3'd4,
    S_READY  = 3'd5
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CNT_W-1:0] dec_floor0(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  logic             lock_p0;
  logic             lock_s;
  state_t           st_q;
  state_t           st_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             loss_inc;
  logic             to_inc;
  logic             ctrl_rst_nxt;
  logic             init_req_nxt;
  logic             ready_nxt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
    end
  end

  // Next-state: one shared down-counter, reloaded whenever a state is entered
  always_comb begin
    st_nxt   = st_q;
    cnt_nxt  = dec_floor0(cnt_q);
    loss_inc = 1'b0;
    to_inc   = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (lock_s) begin
          st_nxt  = S_FILTER;
          cnt_nxt = LD_FILTER;
        end
      end
      S_FILTER: begin
        if (!lock_s) begin
          st_nxt  = S_IDLE;
          cnt_nxt = '0;
        end else if (cnt_q == '0) begin
          st_nxt  = S_HOLD;
          cnt_nxt = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          st_nxt   = S_IDLE;
          cnt_nxt  = '0;
          loss_inc = 1'b1;
        end else if (cnt_q == '0) begin
          st_nxt  = S_PWRUP;
          cnt_nxt = LD_PWRUP;
        end
      end
      S_PWRUP: begin
        if (!lock_s) begin
          st_nxt   = S_IDLE;
          cnt_nxt  = '0;
          loss_inc = 1'b1;
        end else if (cnt_q == '0) begin
          st_nxt  = S_INIT;
          cnt_nxt = LD_INIT;
        end
      end
      S_INIT: begin
        // Lock loss beats ack, and ack beats timeout
        if (!lock_s) begin
          st_nxt   = S_IDLE;
          cnt_nxt  = '0;
          loss_inc = 1'b1;
        end else if (init_ack) begin
          st_nxt  = S_READY;
          cnt_nxt = '0;
        end else if (cnt_q == '0) begin
          st_nxt  = S_HOLD;
          cnt_nxt = LD_HOLD;
          to_inc  = 1'b1;
        end
      end
      S_READY: begin
        if (!lock_s) begin
          st_nxt   = S_IDLE;
          cnt_nxt  = '0;
          loss_inc = 1'b1;
        end
      end
      default: begin
        st_nxt  = S_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the same edge as state
  always_comb begin
    ctrl_rst_nxt = (st_nxt == S_IDLE) || (st_nxt == S_FILTER) || (st_nxt == S_HOLD);
    init_req_nxt = (st_nxt == S_INIT);
    ready_nxt    = (st_nxt == S_READY);
  end

  // Stage p2: state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= S_IDLE;
      cnt_q         <= '0;
      ctrl_rst      <= 1'b1;
      init_req      <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
      timeout_cnt   <= 8'd0;
    end else begin
      st_q     <= st_nxt;
      cnt_q    <= cnt_nxt;
      ctrl_rst <= ctrl_rst_nxt;
      init_req <= init_req_nxt;
      ready    <= ready_nxt;
      if (loss_inc) lock_loss_cnt <= sat_inc8(lock_loss_cnt);
      if (to_inc)   timeout_cnt   <= sat_inc8(timeout_cnt);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_psram_pwr_seq.sv
// Directed bench: default-parameter instance for timing, short-parameter instance for saturation.
module tb_psram_pwr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, lock_a, ack_a, crst_a, ireq_a, rdy_a;
  logic [7:0] loss_a, to_a;
  logic [2:0] st_a;
  logic rst_b, lock_b, ack_b, crst_b, ireq_b, rdy_b;
  logic [7:0] loss_b, to_b;
  logic [2:0] st_b;

  psram_pwr_seq dut_a (
    .clk(clk), .rst(rst_a), .pll_lock(lock_a), .init_ack(ack_a),
    .ctrl_rst(crst_a), .init_req(ireq_a), .ready(rdy_a),
    .lock_loss_cnt(loss_a), .timeout_cnt(to_a), .state(st_a)
  );

  psram_pwr_seq #(
    .LOCK_FILTER(4), .RST_HOLD(2), .PWRUP_CYCLES(3), .INIT_TIMEOUT(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pll_lock(lock_b), .init_ack(ack_b),
    .ctrl_rst(crst_b), .init_req(ireq_b), .ready(rdy_b),
    .lock_loss_cnt(loss_b), .timeout_cnt(to_b), .state(st_b)
  );

  int tests = 0;
  int failed = 0;
  string tag_q[$];
  logic [31:0] exp_q[$];

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty: observed %0d, no expectation queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s: observed %0d expected %0d", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_st_a(input logic [2:0] target, input int budget, output int n);
    n = 0;
    while (st_a !== target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_st_b(input logic [2:0] target, input int budget, output int n);
    n = 0;
    while (st_b !== target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ireq_a(input int budget, output int n);
    n = 0;
    while (ireq_a !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_a = 1'b1; lock_a = 1'b0; ack_a = 1'b0;
    rst_b = 1'b1; lock_b = 1'b0; ack_b = 1'b0;
    repeat (4) step();
    rst_a = 1'b0;

    // Reset values
    push("rst_state", 0);     chk(st_a);
    push("rst_ctrl_rst", 1);  chk(crst_a);
    push("rst_init_req", 0);  chk(ireq_a);
    push("rst_ready", 0);     chk(rdy_a);
    push("rst_loss_cnt", 0);  chk(loss_a);
    push("rst_timeout_cnt", 0); chk(to_a);
    repeat (3) step();
    push("idle_no_lock", 0);  chk(st_a);

    // Full sequence latency from the first edge that samples lock
    lock_a = 1'b1;
    wait_ireq_a(9000, n);
    push("lock_to_init_req", 2 + 64 + 16 + 8100); chk(n - 1);
    push("init_state", 4);    chk(st_a);
    push("init_ctrl_rst", 0); chk(crst_a);
    step(); step();
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    push("ready_state", 5);   chk(st_a);
    push("ready_out", 1);     chk(rdy_a);
    push("ready_init_req", 0); chk(ireq_a);
    push("ready_ctrl_rst", 0); chk(crst_a);
    push("ready_loss_cnt", 0); chk(loss_a);
    push("ready_timeout_cnt", 0); chk(to_a);

    // Lock loss in READY: visible on the third edge
    lock_a = 1'b0;
    step(); step();
    push("loss_ready_edge2", 1); chk(rdy_a);
    step();
    push("loss_ready_edge3", 0); chk(rdy_a);
    push("loss_ctrl_rst", 1);    chk(crst_a);
    push("loss_cnt", 1);         chk(loss_a);
    push("loss_state", 0);       chk(st_a);

    // One-cycle lock glitch during FILTER restarts the filter
    lock_a = 1'b1;
    wait_st_a(3'd1, 10, n);
    push("reach_filter", 1); chk(st_a);
    repeat (10) step();
    lock_a = 1'b0;
    step();
    lock_a = 1'b1;
    wait_st_a(3'd0, 5, n);
    push("glitch_idle", 0); chk(st_a);
    wait_st_a(3'd1, 5, n);
    wait_st_a(3'd2, 100, n);
    push("filter_len", 64);          chk(n);
    push("glitch_loss_unchanged", 1); chk(loss_a);
    wait_ireq_a(9000, n);
    step(); step();
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    push("rerun_ready", 1); chk(rdy_a);

    // rst in READY, then rst in PWRUP
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    push("rst_ready_state", 0); chk(st_a);
    push("rst_ready_ready", 0); chk(rdy_a);
    wait_st_a(3'd3, 200, n);
    push("reach_pwrup", 3); chk(st_a);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    push("pwrup_rst_state", 0);    chk(st_a);
    push("pwrup_rst_ctrl_rst", 1); chk(crst_a);
    push("pwrup_rst_init_req", 0); chk(ireq_a);
    push("pwrup_rst_ready", 0);    chk(rdy_a);
    push("pwrup_rst_loss", 0);     chk(loss_a);
    push("pwrup_rst_timeout", 0);  chk(to_a);

    // INIT timeout without ack
    wait_st_a(3'd4, 9000, n);
    push("reach_init", 4); chk(st_a);
    wait_st_a(3'd2, 1100, n);
    push("init_timeout_len", 1024); chk(n);
    push("timeout_cnt_1", 1);       chk(to_a);
    push("timeout_ctrl_rst", 1);    chk(crst_a);

    // Ack on the final INIT cycle wins over the timeout
    wait_st_a(3'd4, 9000, n);
    repeat (1023) step();
    push("init_last_cycle", 4); chk(st_a);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    push("ack_vs_timeout_state", 5); chk(st_a);
    push("ack_vs_timeout_cnt", 1);   chk(to_a);

    // Short-parameter instance
    rst_b = 1'b0;
    lock_b = 1'b1;
    wait_st_b(3'd1, 10, n);
    ack_b = 1'b1;
    step();
    ack_b = 1'b0;
    push("b_ack_ignored_state", 1); chk(st_b);
    push("b_ack_ignored_ready", 0); chk(rdy_b);

    // Lock drop coincident with ack in INIT
    wait_st_b(3'd4, 20, n);
    lock_b = 1'b0;
    step(); step();
    ack_b = 1'b1;
    step();
    ack_b = 1'b0;
    push("b_loss_vs_ack_state", 0); chk(st_b);
    push("b_loss_vs_ack_loss", 1);  chk(loss_b);
    push("b_loss_vs_ack_to", 0);    chk(to_b);
    push("b_loss_vs_ack_ready", 0); chk(rdy_b);

    // Repeated timeouts saturate timeout_cnt
    lock_b = 1'b1;
    n = 0;
    while (to_b !== 8'd255 && n < 4000) begin
      step();
      n++;
    end
    push("b_timeout_reach_255", 255); chk(to_b);
    repeat (100) step();
    push("b_timeout_saturated", 255); chk(to_b);
    push("b_loss_stable", 1);         chk(loss_b);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/psram_pwr_seq.md
PSRAM_PWR_SEQ -- requirements
Module: psram_pwr_seq

Interface
REQ-001 Parameter LOCK_FILTER, default 64: consecutive synchronized-lock-high cycles required before leaving FILTER.
REQ-002 Parameter RST_HOLD, default 16: cycles ctrl_rst is held in HOLD.
REQ-003 Parameter PWRUP_CYCLES, default 8100: power-up wait, 150 us at the 54 MHz PLL clkout.
REQ-004 Parameter INIT_TIMEOUT, default 1024: maximum INIT cycles awaiting init_ack.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  PLL clkout; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 pll_lock  in  1  PLL lock indication, asynchronous to clk.
REQ-009 ctrl_rst  out  1  active-high reset to the downstream PSRAM controller.
REQ-010 init_req  out  1  request to the controller to issue the PSRAM reset/config command sequence.
REQ-011 init_ack  in  1  single-cycle-or-longer acknowledge that the init sequence completed.
REQ-012 ready  out  1  PSRAM usable; high only in READY.
REQ-013 lock_loss_cnt  out  8  saturating count of lock drops after FILTER.
REQ-014 timeout_cnt  out  8  saturating count of INIT timeouts.
REQ-015 state  out  3  current state encoding: IDLE=0, FILTER=1, HOLD=2, PWRUP=3, INIT=4, READY=5.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer; lock_s (second flop) is the only lock signal used; latency is 2 cycles.
REQ-017 A single down-counter SHALL be shared across states, sized to the largest parameter, and loaded on every state entry.
REQ-018 IDLE: ctrl_rst=1, init_req=0; lock_s=1 -> FILTER with counter=LOCK_FILTER-1.
REQ-019 FILTER: lock_s=0 -> IDLE with no lock_loss_cnt increment; counter==0 with lock_s=1 -> HOLD with counter=RST_HOLD-1.
REQ-020 HOLD: ctrl_rst=1; counter==0 -> PWRUP with counter=PWRUP_CYCLES-1.
REQ-021 PWRUP: ctrl_rst=0 from the first PWRUP cycle; counter==0 -> INIT with counter=INIT_TIMEOUT-1.
REQ-022 INIT: init_req=1 registered, asserted from the first INIT cycle; init_ack=1 -> READY next cycle, init_req=0 in READY.
REQ-023 INIT with counter==0 and init_ack=0 -> HOLD, timeout_cnt+1 saturating at 255, counter=RST_HOLD-1.
REQ-024 INIT with init_ack=1 on the counter==0 cycle SHALL go to READY; ack wins over timeout.
REQ-025 init_ack outside INIT SHALL be ignored.
REQ-026 READY: ready=1, ctrl_rst=0, init_req=0; remains until lock loss or rst.
REQ-027 lock_s=0 in HOLD, PWRUP, INIT or READY SHALL force IDLE next cycle, set ctrl_rst=1, ready=0, init_req=0 in that same next cycle, and increment lock_loss_cnt saturating at 255.
REQ-028 A lock drop coincident with init_ack or a timeout SHALL take priority: go to IDLE, lock_loss_cnt only.
REQ-029 All outputs SHALL be registered; no combinational path from an input to an output.
REQ-030 Undefined state encodings SHALL return to IDLE.

Reset
REQ-031 rst=1 SHALL, on the next edge, set: state=IDLE; ctrl_rst=1; init_req=0; ready=0; lock_loss_cnt=0; timeout_cnt=0; counter=0; synchronizer flops=0.
REQ-032 rst asserted mid-sequence, including READY or INIT, SHALL abort immediately with the values above; the sequence restarts from IDLE after rst falls.

Verification
REQ-033 Defaults; rst 4 cycles, then pll_lock=1 held and init_ack pulsed 3 cycles after init_req rises -> init_req rises exactly 2+64+16+8100 cycles after the lock edge; ready=1 one cycle after the ack; counters=0.
REQ-034 pll_lock glitch low for 1 cycle during FILTER -> state returns to IDLE, FILTER restarts its 64-cycle count, lock_loss_cnt stays 0.
REQ-035 In READY, pll_lock=0 -> 3 cycles later (2 synchronizer + 1) ready=0, ctrl_rst=1, lock_loss_cnt=1; a full sequence reruns when lock returns.
REQ-036 init_ack never asserted -> after 1024 INIT cycles state=HOLD, timeout_cnt=1; repeat 300 times -> timeout_cnt saturates at 255.
REQ-037 init_ack and a timeout on the same cycle -> READY, timeout_cnt unchanged; separately, rst pulsed during PWRUP -> all outputs at reset values on the next cycle.
